simon_serial_host: RTL and testbench
====================================

// Module: simon_serial_host
// PURPOSE
//  Parallel-to-serial front end for the bit-serial SIMON core (simon_module).
//  Accepts a parallel plaintext block and key, shifts them into the core over
//  data_in/data_rdy, then starts encryption. It captures the serial cipher_out
//  stream while the core asserts valid and returns the ciphertext in parallel.
//  Sits between the chip-level register/IO logic and the core; drives the
//  core's input pins and receives its output pins.
// PARAMETERS
//  BLOCK_W    64     plaintext/ciphertext width in bits (core block size)
//  KEY_W      128    key width in bits shifted in during LOAD_KEY
//  TIMEOUT_W  12     width of the wait-for-valid watchdog counter
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  reset        in   1        asynchronous, active-low; clears all state
//  start        in   1        pulse/level: begin one encryption (sampled in IDLE only)
//  pt_in        in   BLOCK_W  plaintext, latched on accepted start
//  key_in       in   KEY_W    key, latched on accepted start
//  busy         out  1        high from accepted start until done pulse
//  done         out  1        one-cycle pulse: ct_out valid / timeout reported
//  timeout      out  1        sticky until next accepted start; set if valid never seen
//  ct_out       out  BLOCK_W  captured ciphertext, held until next done
//  core_data_in out  1        serial bit to core data_in
//  core_rdy     out  2        to core data_rdy: 00 idle,01 load pt,10 load key,11 run
//  core_out     in   1        from core cipher_out (debug_port tied 0 at top)
//  core_valid   in   1        from core valid
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; busy=0, done=0, timeout=0, ct_out=0,
//   core_data_in=0, core_rdy=2'b00; all counters 0.
//  FSM: IDLE -> LOAD_PT -> LOAD_KEY -> RUN -> CAPTURE -> IDLE.
//  IDLE: on start==1, latch pt_in/key_in into shift regs, clear timeout, busy=1,
//   go LOAD_PT. start while busy is ignored (no queuing).
//  LOAD_PT: exactly BLOCK_W cycles; core_rdy=01, core_data_in = pt bit, LSB first,
//   one bit per cycle. Bit counter wraps BLOCK_W-1 -> 0 on exit to LOAD_KEY.
//  LOAD_KEY: exactly KEY_W cycles; core_rdy=10, key LSB first. Exit to RUN.
//  RUN: core_rdy=11, core_data_in=0; watchdog counts up each cycle. On
//   core_valid==1, go CAPTURE and take core_out as ct bit 0 the same cycle.
//   If watchdog reaches all-ones with no valid: timeout=1, done pulse,
//   ct_out unchanged, core_rdy=00, return IDLE.
//  CAPTURE: core_rdy stays 11; shift core_out into ct shift reg (LSB first) each
//   cycle, BLOCK_W bits total including the RUN-exit bit. After bit BLOCK_W-1:
//   ct_out <= shift reg, done=1 for one cycle, busy=0 same cycle, core_rdy=00,
//   state IDLE. If core_valid drops before BLOCK_W bits: capture continues
//   regardless (core guarantees contiguous valid); no error flag.
//  done and the next start: start in the done cycle is accepted only from IDLE,
//   i.e. earliest one cycle after done.
//  Latency: accepted start -> done = BLOCK_W + KEY_W + Tcore + BLOCK_W cycles,
//   Tcore = cycles in RUN before first valid.
//  Reset mid-operation: immediate abort to reset values; core is reset by the
//   same net, so no cleanup sequence is required.
//  All registered outputs; core_data_in/core_rdy change only on clk edges.
// STRUCTURE
//  Shared package/header simon_pkg: localparams RDY_IDLE=2'b00, RDY_PT=2'b01,
//   RDY_KEY=2'b10, RDY_RUN=2'b11; FSM state encoding; BLOCK_W/KEY_W defaults.
//  One sub-module: simon_piso_sipo (generic width shift register with load,
//   shift-out LSB and shift-in MSB modes), instanced for pt, key and ct.
//  Bit counter sized $clog2(KEY_W) shared by LOAD_PT/LOAD_KEY/CAPTURE.
// TESTING
//  1 Reset: hold reset=0 mid-LOAD_KEY -> all outputs 0, core_rdy=00 next cycle.
//  2 Load order: pt=64'h0000_0000_0000_0001 -> core_data_in=1 only on 1st
//    LOAD_PT cycle; core_rdy=01 for exactly 64 cycles, then 10 for 128.
//  3 Loopback with behavioural core model (valid after 10 RUN cycles, streams
//    64'hDEAD_BEEF_0123_4567 LSB first) -> ct_out=64'hDEAD_BEEF_0123_4567,
//    one-cycle done, busy falls with done.
//  4 Real simon_module, key bits forced by core: pt=64'h6565_6877_6564_6F6C ->
//    ct_out matches golden C model for the forced key; timeout=0.
//  5 Timeout: core_valid tied 0 -> done after 4095 RUN cycles, timeout=1,
//    ct_out keeps previous value; next start clears timeout.
//  6 start held high through busy -> only one transaction; back-to-back start
//    one cycle after done -> second transaction begins cleanly.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants for the SIMON serial host: core data_rdy codes, FSM states
// and default block/key/watchdog widths.
package simon_pkg;

  localparam int BLOCK_W_DEF   = 64;
  localparam int KEY_W_DEF     = 128;
  localparam int TIMEOUT_W_DEF = 12;

  localparam logic [1:0] RDY_IDLE = 2'b00;
  localparam logic [1:0] RDY_PT   = 2'b01;
  localparam logic [1:0] RDY_KEY  = 2'b10;
  localparam logic [1:0] RDY_RUN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_PT  = 3'd1,
    ST_LOAD_KEY = 3'd2,
    ST_RUN      = 3'd3,
    ST_CAPTURE  = 3'd4
  } state_t;

endpackage

// File: rtl/simon_piso_sipo.sv
// Generic right-shifting register: parallel load, or shift with a serial bit
// entering at the MSB (tie i_sin low for parallel-in/serial-out use).
module simon_piso_sipo #(
  parameter int W     = 64,
  parameter int OUT_W = W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [W-1:0]     i_din,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [OUT_W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[W-1:1]};
    end
  end

  // Serial users only need the low bits; the rest stay internal.
  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/simon_serial_host.sv
// Parallel-to-serial front end for the bit-serial SIMON core: shifts pt and key
// in LSB first, waits for valid (with watchdog), then gathers the serial ciphertext.
module simon_serial_host
  import simon_pkg::*;
#(
  parameter int BLOCK_W   = BLOCK_W_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] pt_in,
  input  logic [KEY_W-1:0]   key_in,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [BLOCK_W-1:0] ct_out,
  output logic               core_data_in,
  output logic [1:0]         core_rdy,
  input  logic               core_out,
  input  logic               core_valid
);

  localparam int CNT_W = $clog2(KEY_W);
  localparam logic [CNT_W-1:0]     PT_LAST  = CNT_W'(BLOCK_W - 1);
  localparam logic [CNT_W-1:0]     KEY_LAST = CNT_W'(KEY_W - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [TIMEOUT_W-1:0] r_wd, w_wd_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 r_timeout, w_timeout_next;
  logic [BLOCK_W-1:0]   r_ct_out, w_ct_out_next;
  logic                 r_data, w_data_next;
  logic [1:0]           r_rdy, w_rdy_next;

  logic               w_load, w_pt_shift, w_key_shift, w_ct_shift;
  logic [0:0]         w_pt_q, w_key_q;
  logic [BLOCK_W-2:0] w_ct_q;

  // pt bit 0 goes straight to the output register on start, so the shifter
  // holds the remaining bits with bit 1 already at its LSB.
  simon_piso_sipo #(.W(BLOCK_W), .OUT_W(1)) u_pt_sr (
    .clk(clk), .reset(reset), .i_load(w_load), .i_din({1'b0, pt_in[BLOCK_W-1:1]}),
    .i_shift(w_pt_shift), .i_sin(1'b0), .o_q(w_pt_q)
  );

  simon_piso_sipo #(.W(KEY_W), .OUT_W(1)) u_key_sr (
    .clk(clk), .reset(reset), .i_load(w_load), .i_din(key_in),
    .i_shift(w_key_shift), .i_sin(1'b0), .o_q(w_key_q)
  );

  // One bit narrower than the block: the last ciphertext bit is merged in
  // directly when ct_out is written.
  simon_piso_sipo #(.W(BLOCK_W-1)) u_ct_sr (
    .clk(clk), .reset(reset), .i_load(1'b0), .i_din('0),
    .i_shift(w_ct_shift), .i_sin(core_out), .o_q(w_ct_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_ct_out  <= '0;
      r_data    <= 1'b0;
      r_rdy     <= RDY_IDLE;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wd      <= w_wd_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_timeout <= w_timeout_next;
      r_ct_out  <= w_ct_out_next;
      r_data    <= w_data_next;
      r_rdy     <= w_rdy_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wd_next      = r_wd;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_timeout_next = r_timeout;
    w_ct_out_next  = r_ct_out;
    w_data_next    = r_data;
    w_rdy_next     = r_rdy;
    w_load         = 1'b0;
    w_pt_shift     = 1'b0;
    w_key_shift    = 1'b0;
    w_ct_shift     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load         = 1'b1;
          w_timeout_next = 1'b0;
          w_busy_next    = 1'b1;
          w_data_next    = pt_in[0];
          w_rdy_next     = RDY_PT;
          w_cnt_next     = '0;
          w_state_next   = ST_LOAD_PT;
        end
      end
      ST_LOAD_PT: begin
        w_pt_shift = 1'b1;
        if (r_cnt == PT_LAST) begin
          // Key bit 0 is presented next; advance the key shifter to bit 1.
          w_key_shift  = 1'b1;
          w_data_next  = w_key_q[0];
          w_rdy_next   = RDY_KEY;
          w_cnt_next   = '0;
          w_state_next = ST_LOAD_KEY;
        end else begin
          w_data_next = w_pt_q[0];
          w_cnt_next  = r_cnt + 1'b1;
        end
      end
      ST_LOAD_KEY: begin
        w_key_shift = 1'b1;
        if (r_cnt == KEY_LAST) begin
          w_data_next  = 1'b0;
          w_rdy_next   = RDY_RUN;
          w_cnt_next   = '0;
          w_wd_next    = '0;
          w_state_next = ST_RUN;
        end else begin
          w_data_next = w_key_q[0];
          w_cnt_next  = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (core_valid) begin
          w_ct_shift   = 1'b1;
          w_cnt_next   = CNT_W'(1);
          w_state_next = ST_CAPTURE;
        end else if (r_wd == WD_LAST) begin
          w_wd_next      = '0;
          w_timeout_next = 1'b1;
          w_done_next    = 1'b1;
          w_busy_next    = 1'b0;
          w_rdy_next     = RDY_IDLE;
          w_state_next   = ST_IDLE;
        end else begin
          w_wd_next = r_wd + 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_ct_shift = 1'b1;
        if (r_cnt == PT_LAST) begin
          w_ct_out_next = {core_out, w_ct_q};
          w_done_next   = 1'b1;
          w_busy_next   = 1'b0;
          w_rdy_next    = RDY_IDLE;
          w_cnt_next    = '0;
          w_state_next  = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout      = r_timeout;
  assign ct_out       = r_ct_out;
  assign core_data_in = r_data;
  assign core_rdy     = r_rdy;

endmodule

// File: tb/tb_simon_serial_host.sv
// Directed bench for simon_serial_host with a behavioural core model that
// raises valid after a programmable number of RUN cycles and streams a pattern.
module tb_simon_serial_host;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  pt_in;
  logic [127:0] key_in;
  logic         busy, done, timeout;
  logic [63:0]  ct_out;
  logic         core_data_in;
  logic [1:0]   core_rdy;
  logic         core_out = 1'b0;
  logic         core_valid = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  int          m_tc = 0;
  logic [63:0] m_pat = '0;
  bit          model_en = 1'b0;
  int          rc = 0;
  int          bi = 0;

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    int           tc;
    logic [63:0]  pat;
    int           exp_lat;
  } vec_t;

  vec_t vecs[4];

  simon_serial_host dut (
    .clk(clk), .reset(reset), .start(start), .pt_in(pt_in), .key_in(key_in),
    .busy(busy), .done(done), .timeout(timeout), .ct_out(ct_out),
    .core_data_in(core_data_in), .core_rdy(core_rdy),
    .core_out(core_out), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  // Core model: idles unless data_rdy==11, then waits m_tc cycles and streams m_pat LSB first.
  always @(negedge clk) begin
    if (core_rdy != 2'b11) begin
      rc = 0;
      bi = 0;
      core_valid = 1'b0;
      core_out = 1'b0;
    end else if (model_en) begin
      if (rc < m_tc) begin
        rc++;
        core_valid = 1'b0;
      end else if (bi < 64) begin
        core_valid = 1'b1;
        core_out = m_pat[bi[5:0]];
        bi++;
      end else begin
        core_valid = 1'b0;
      end
    end else begin
      core_valid = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic [63:0] pt, input logic [127:0] key,
                        input int tc, input logic [63:0] pat, input bit en, input bit hold,
                        input int exp_lat, input bit exp_to, input logic [63:0] exp_ct);
    int           k;
    int           pt_n;
    int           key_n;
    logic [63:0]  pt_cap;
    logic [127:0] key_cap;
    bit           run_bad;
    bit           busy_bad;
    bit           seen;
    k = 0; pt_n = 0; key_n = 0; pt_cap = '0; key_cap = '0;
    run_bad = 1'b0; busy_bad = 1'b0; seen = 1'b0;
    m_tc = tc; m_pat = pat; model_en = en;
    pt_in = pt; key_in = key; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk({tag, "_timeout_cleared"}, 128'(timeout), 128'(0));
    while (!seen && k < 6000) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        case (core_rdy)
          2'b01: begin
            if (pt_n < 64) pt_cap[pt_n[5:0]] = core_data_in;
            pt_n++;
          end
          2'b10: begin
            if (key_n < 128) key_cap[key_n[6:0]] = core_data_in;
            key_n++;
          end
          2'b11: if (core_data_in !== 1'b0) run_bad = 1'b1;
          default: busy_bad = 1'b1;
        endcase
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_done_wait: got no done after %0d cycles, expected done after %0d", tag, k, exp_lat);
    end
    $display("txn %s: latency=%0d ct_out=%h timeout=%0b", tag, k, ct_out, timeout);
    chk({tag, "_latency"}, 128'(k), 128'(exp_lat));
    chk({tag, "_ct_out"}, 128'(ct_out), 128'(exp_ct));
    chk({tag, "_timeout"}, 128'(timeout), 128'(exp_to));
    chk({tag, "_busy_at_done"}, 128'(busy), 128'(0));
    chk({tag, "_rdy_at_done"}, 128'(core_rdy), 128'(0));
    chk({tag, "_pt_stream"}, 128'(pt_cap), 128'(pt));
    chk({tag, "_pt_cycles"}, 128'(pt_n), 128'(64));
    chk({tag, "_key_stream"}, key_cap, key);
    chk({tag, "_key_cycles"}, 128'(key_n), 128'(128));
    chk({tag, "_run_data_zero"}, 128'(run_bad), 128'(0));
    chk({tag, "_busy_held"}, 128'(busy_bad), 128'(0));
    if (hold) start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
    chk({tag, "_idle_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    vecs[0] = '{pt: 64'h0000_0000_0000_0001, key: 128'h1, tc: 10,
                pat: 64'hDEAD_BEEF_0123_4567, exp_lat: 266};
    vecs[1] = '{pt: 64'h6565_6877_6564_6F6C, key: 128'h1B1A_1918_1312_1110_0B0A_0908_0302_0100,
                tc: 0, pat: 64'hA5A5_0F0F_FFFF_0001, exp_lat: 256};
    vecs[2] = '{pt: 64'hFFFF_FFFF_FFFF_FFFF, key: 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                tc: 37, pat: 64'h8000_0000_0000_0000, exp_lat: 293};
    vecs[3] = '{pt: 64'h0000_0000_0000_0000, key: 128'h0, tc: 3,
                pat: 64'h0123_4567_89AB_CDEF, exp_lat: 259};

    reset = 1'b0; start = 1'b0; pt_in = '0; key_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_timeout", 128'(timeout), 128'(0));
    chk("reset_ct_out", 128'(ct_out), 128'(0));
    chk("reset_data", 128'(core_data_in), 128'(0));
    chk("reset_rdy", 128'(core_rdy), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // Consecutive calls start one cycle after the previous done pulse.
    for (int i = 0; i < 4; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key, vecs[i].tc, vecs[i].pat,
             1'b1, 1'b0, vecs[i].exp_lat, 1'b0, vecs[i].pat);
    end

    do_txn("watchdog", 64'h1234_5678_9ABC_DEF0, 128'h5555, 0, 64'h0, 1'b0, 1'b0,
           64 + 128 + 4095, 1'b1, vecs[3].pat);

    do_txn("start_held", 64'hCAFE_F00D_0000_0003, 128'hFFFF_0000, 5, 64'h0F1E_2D3C_4B5A_6978,
           1'b1, 1'b1, 261, 1'b0, 64'h0F1E_2D3C_4B5A_6978);
    @(negedge clk);
    chk("start_held_no_retrigger", 128'(core_rdy), 128'(0));

    pt_in = 64'h1; key_in = {128{1'b1}}; m_tc = 4; model_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("midkey_rdy", 128'(core_rdy), 128'(2'b10));
    chk("midkey_data", 128'(core_data_in), 128'(1));
    reset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_timeout", 128'(timeout), 128'(0));
    chk("abort_ct_out", 128'(ct_out), 128'(0));
    chk("abort_data", 128'(core_data_in), 128'(0));
    chk("abort_rdy", 128'(core_rdy), 128'(0));
    @(negedge clk);
    chk("abort_rdy_next", 128'(core_rdy), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    do_txn("recover", 64'hFEDC_BA98_7654_3210, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
           20, 64'h5A5A_5A5A_C3C3_C3C3, 1'b1, 1'b0, 276, 1'b0, 64'h5A5A_5A5A_C3C3_C3C3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
